// File: rtl/sordm5_mem_arbiter.sv
// Sord M5 SDRAM port arbiter: download FIFO + CPU bus share one SDRAM controller port.
// Latency: ioctl_wr -> mem_req in 2 cycles (FIFO empty, idle); cpu_req -> mem_req in 1 cycle.
// Backpressure: none upstream; a strobe into a full FIFO is dropped and flags dl_overflow.
// Optional feature: define SORDM5_ARB_RR_EN for round-robin DL/CPU arbitration.

// Small power-of-two FIFO with a combinational head read.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push when full is ignored, pop when empty is ignored.
module sordm5_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // A full FIFO drops the push even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves cnt unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_FULL);
endmodule

// Arbiter top: relocates download bytes, queues them, and shares the SDRAM port with the CPU.
// Latency: DL byte reaches mem_req 2 cycles after ioctl_wr; CPU ack 1 cycle after mem_ack.
// Backpressure: mem_req held until mem_ack; CPU waits on cpu_ack; overflowing bytes dropped.
module sordm5_mem_arbiter #(
  parameter int                 ADDR_W        = 25,
  parameter int                 DL_FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  TAPE_BASE     = 25'h100000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              dl_busy,
  output logic [ADDR_W-1:0] cas_size,
  output logic              dl_overflow
);
  localparam int ENT_W = ADDR_W + 8;
  localparam int CNT_W = $clog2(DL_FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DL_ISSUE, CPU_ISSUE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] mapped_addr;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_pop;
  logic              fifo_nonempty_next;
  logic              cpu_pending;
  logic              grant_dl;
  logic              mem_req_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [7:0]        mem_din_n;
  logic              cpu_ack_n;
  logic [7:0]        cpu_dout_n;
  logic              dl_prev;
  logic              dl_rise;
  logic              dl_fall;
  logic              cas_wr;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] max_p1;
  logic              unused_idx;

  // Only bit 1 of the image index steers relocation.
  assign unused_idx  = ^{ioctl_index[7:2], ioctl_index[0]};
  assign mapped_addr = ioctl_index[1] ? (TAPE_BASE + ioctl_addr) : ioctl_addr;

  sordm5_fifo #(.W(ENT_W), .DEPTH(DL_FIFO_DEPTH)) u_dl_fifo (
    .clk      (clk_sys),
    .reset    (reset),
    .push     (ioctl_wr),
    .push_dat ({mapped_addr, ioctl_dout}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .cnt      (fifo_cnt)
  );

  // cpu_req is still high in the cycle cpu_ack is out; masking it stops a duplicate grant.
  assign cpu_pending = cpu_req & ~cpu_ack;

`ifdef SORDM5_ARB_RR_EN
  logic last_dl;
  assign grant_dl = ~fifo_empty & (~cpu_pending | ~last_dl);

  // Remember which side won the last grant so the other side goes next when both wait.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      last_dl <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_dl)         last_dl <= 1'b1;
      else if (cpu_pending) last_dl <= 1'b0;
    end
  end
`else
  assign grant_dl = ~fifo_empty;
`endif

  // Next-state and next-output logic for the grant/issue FSM.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    mem_req_n  = mem_req;
    mem_we_n   = mem_we;
    mem_addr_n = mem_addr;
    mem_din_n  = mem_din;
    cpu_ack_n  = 1'b0;
    cpu_dout_n = cpu_dout;
    unique case (state)
      IDLE: begin
        if (grant_dl) begin
          fifo_pop   = 1'b1;
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b1;
          mem_addr_n = fifo_head[ENT_W-1:8];
          mem_din_n  = fifo_head[7:0];
          state_next = DL_ISSUE;
        end else if (cpu_pending) begin
          mem_req_n  = 1'b1;
          mem_we_n   = cpu_we;
          mem_addr_n = cpu_addr;
          mem_din_n  = cpu_din;
          state_next = CPU_ISSUE;
        end
      end
      DL_ISSUE: begin
        if (mem_ack) begin
          mem_req_n  = 1'b0;
          state_next = IDLE;
        end
      end
      CPU_ISSUE: begin
        if (mem_ack) begin
          mem_req_n  = 1'b0;
          cpu_ack_n  = 1'b1;
          if (!mem_we) cpu_dout_n = mem_dout;
          state_next = IDLE;
        end
      end
      default: begin
        mem_req_n  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Occupancy after this edge, so dl_busy drops in the cycle the last write completes.
  assign fifo_nonempty_next = (ioctl_wr & ~fifo_full) | (fifo_cnt > CNT_ONE) |
                              (~fifo_empty & ~fifo_pop);

  // State register and registered SDRAM/CPU-side outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_ack  <= 1'b0;
      cpu_dout <= '0;
      dl_busy  <= 1'b0;
    end else begin
      state    <= state_next;
      mem_req  <= mem_req_n;
      mem_we   <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_din  <= mem_din_n;
      cpu_ack  <= cpu_ack_n;
      cpu_dout <= cpu_dout_n;
      dl_busy  <= ioctl_download | fifo_nonempty_next | (state_next == DL_ISSUE);
    end
  end

  assign dl_rise = ioctl_download & ~dl_prev;
  assign dl_fall = ~ioctl_download & dl_prev;
  assign cas_wr  = ioctl_wr & ioctl_download & ioctl_index[1];
  assign addr_p1 = ioctl_addr + ADDR_ONE;

  // Download edge tracking: overflow flag, running CAS length, and its capture at the end.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev     <= 1'b0;
      dl_overflow <= 1'b0;
      max_p1      <= '0;
      cas_size    <= '0;
    end else begin
      dl_prev <= ioctl_download;
      if (ioctl_wr && fifo_full) dl_overflow <= 1'b1;
      else if (dl_rise)          dl_overflow <= 1'b0;
      if (dl_rise)                         max_p1 <= cas_wr ? addr_p1 : '0;
      else if (cas_wr && addr_p1 > max_p1) max_p1 <= addr_p1;
      if (dl_fall && ioctl_index[1]) cas_size <= max_p1;
    end
  end
endmodule

// File: tb/tb_sordm5_mem_arbiter.sv
module tb_sordm5_mem_arbiter;
  localparam int ADDR_W = 25;

  logic              clk_sys;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ack;
  logic              dl_busy;
  logic [ADDR_W-1:0] cas_size;
  logic              dl_overflow;

  int checks = 0;
  int passed = 0;

  // Scoreboard entries: {we, addr, din}
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];

  int       ack_delay = 0;
  bit       ack_hold  = 1'b0;
  logic [7:0] rd_data = 8'h00;

  sordm5_mem_arbiter dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .cpu_ack        (cpu_ack),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_ack        (mem_ack),
    .dl_busy        (dl_busy),
    .cas_size       (cas_size),
    .dl_overflow    (dl_overflow)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // SDRAM controller model: acks a held request after ack_delay extra cycles, logs it.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    mem_dout = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ack = 1'b0;
      if (mem_req && !ack_hold && !reset) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          mem_dout = rd_data;
          obs_q.push_back({mem_we, mem_addr, mem_din});
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic wait_cpu_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b required 0", mem_req); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b required 0", mem_we); else passed++;
    checks++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack: got %b required 0", cpu_ack); else passed++;
    checks++; if (dl_busy !== 1'b0) $display("FAIL reset_dl_busy: got %b required 0", dl_busy); else passed++;
    checks++; if (dl_overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", dl_overflow); else passed++;
    checks++; if (mem_addr !== '0 || mem_din !== 8'h00) $display("FAIL reset_mem_bus: got addr=%h din=%h required 0", mem_addr, mem_din); else passed++;
    checks++; if (cpu_dout !== 8'h00 || cas_size !== '0) $display("FAIL reset_cpu_cas: got dout=%h cas=%h required 0", cpu_dout, cas_size); else passed++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rom_download();
    bit ok;
    logic [33:0] got, want;
    obs_q.delete(); exp_q.delete();
    ack_delay = 0;
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h0; ioctl_dout = 8'h3E;
    exp_q.push_back({1'b1, 25'h0, 8'h3E});
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h1; ioctl_dout = 8'h01;
    exp_q.push_back({1'b1, 25'h1, 8'h01});
    @(negedge clk_sys);
    checks++; if (mem_req !== 1'b0) $display("FAIL rom_req_t1: got %b required 0", mem_req); else passed++;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h0) $display("FAIL rom_req_t2: got req=%b addr=%h required 1/0", mem_req, mem_addr); else passed++;
    checks++; if (dl_busy !== 1'b1) $display("FAIL rom_busy_high: got %b required 1", dl_busy); else passed++;
    wait_log(2, ok);
    checks++; if (!ok) $display("FAIL rom_timeout: got %0d writes required 2", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) $display("FAIL rom_write: got %h required %h", got, want); else passed++;
    end
    tick();
    @(negedge clk_sys);
    checks++; if (dl_busy !== 1'b0) $display("FAIL rom_busy_fall: got %b required 0", dl_busy); else passed++;
    tick();
  endtask

  task automatic test_cas_download();
    bit ok;
    logic [33:0] got, want;
    logic [7:0] d;
    obs_q.delete(); exp_q.delete();
    ioctl_index = 8'h02; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      d = 8'(i) ^ 8'hA5;
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = d;
      exp_q.push_back({1'b1, 25'h100000 + 25'(i), d});
      tick();
      ioctl_wr = 1'b0;
      tick();
      tick();
    end
    ioctl_download = 1'b0;
    wait_log(300, ok);
    checks++; if (!ok) $display("FAIL cas_timeout: got %0d writes required 300", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) $display("FAIL cas_write: got %h required %h", got, want); else passed++;
    end
    tick(); tick();
    checks++; if (cas_size !== 25'd300) $display("FAIL cas_size: got %0d required 300", cas_size); else passed++;
    checks++; if (dl_overflow !== 1'b0) $display("FAIL cas_overflow: got %b required 0", dl_overflow); else passed++;
  endtask

  task automatic test_cpu_read();
    logic [33:0] got, want;
    int ack_cnt;
    bit seen;
    obs_q.delete(); exp_q.delete();
    ack_delay = 2; rd_data = 8'h5A;
    ioctl_index = 8'h00;
    cpu_we = 1'b0; cpu_addr = 25'h0000A5; cpu_din = 8'h00; cpu_req = 1'b1;
    exp_q.push_back({1'b0, 25'h0000A5, 8'h00});
    @(negedge clk_sys);
    checks++; if (mem_req !== 1'b0) $display("FAIL cpu_req_t0: got %b required 0", mem_req); else passed++;
    tick();
    @(negedge clk_sys);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL cpu_req_t1: got req=%b we=%b required 1/0", mem_req, mem_we); else passed++;
    ack_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin
        ack_cnt++;
        if (!seen) begin
          seen = 1'b1;
          checks++; if (cpu_dout !== 8'h5A) $display("FAIL cpu_dout: got %h required 5a", cpu_dout); else passed++;
        end
      end
      @(posedge clk_sys);
      #1;
      if (seen) cpu_req = 1'b0;
    end
    checks++; if (ack_cnt != 1) $display("FAIL cpu_ack_count: got %0d required 1", ack_cnt); else passed++;
    checks++; if (cpu_dout !== 8'h5A) $display("FAIL cpu_dout_hold: got %h required 5a", cpu_dout); else passed++;
    checks++; if (obs_q.size() != 1) $display("FAIL cpu_access_count: got %0d required 1", obs_q.size()); else passed++;
    if (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) $display("FAIL cpu_access: got %h required %h", got, want); else passed++;
    end
    ack_delay = 0;
  endtask

  task automatic test_overflow();
    bit ok;
    logic [33:0] got, want;
    obs_q.delete(); exp_q.delete();
    ack_hold = 1'b1;
    cpu_we = 1'b1; cpu_addr = 25'h77; cpu_din = 8'h11; cpu_req = 1'b1;
    exp_q.push_back({1'b1, 25'h77, 8'h11});
    tick(); tick();
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h40 + 25'(i); ioctl_dout = 8'hD0 + 8'(i);
      if (i < 4) exp_q.push_back({1'b1, 25'h40 + 25'(i), 8'hD0 + 8'(i)});
      tick();
      checks++;
      if (dl_overflow !== (i == 4)) $display("FAIL ovf_strobe%0d: got %b required %b", i, dl_overflow, (i == 4));
      else passed++;
    end
    ioctl_wr = 1'b0;
    repeat (4) tick();
    ack_hold = 1'b0;
    wait_cpu_ack(40, ok);
    checks++; if (!ok) $display("FAIL ovf_cpu_ack: got none required pulse"); else passed++;
    tick();
    cpu_req = 1'b0;
    ioctl_download = 1'b0;
    wait_log(5, ok);
    checks++; if (!ok) $display("FAIL ovf_timeout: got %0d accesses required 5", obs_q.size()); else passed++;
    repeat (5) tick();
    checks++; if (obs_q.size() != 5) $display("FAIL ovf_access_count: got %0d required 5", obs_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) $display("FAIL ovf_access: got %h required %h", got, want); else passed++;
    end
    checks++; if (dl_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", dl_overflow); else passed++;
    ioctl_download = 1'b1;
    tick();
    checks++; if (dl_overflow !== 1'b0) $display("FAIL ovf_clear: got %b required 0", dl_overflow); else passed++;
    ioctl_download = 1'b0;
    tick(); tick();
    checks++; if (cas_size !== 25'd300) $display("FAIL cas_hold: got %0d required 300", cas_size); else passed++;
  endtask

  task automatic test_priority();
    bit ok;
    logic [33:0] got, want;
    logic [33:0] cpu1, cpu2, dl0, dl1, dl2;
    obs_q.delete(); exp_q.delete();
    cpu1 = {1'b1, 25'h200, 8'h22};
    cpu2 = {1'b0, 25'h300, 8'h00};
    dl0  = {1'b1, 25'h80, 8'hE0};
    dl1  = {1'b1, 25'h81, 8'hE1};
    dl2  = {1'b1, 25'h82, 8'hE2};
`ifdef SORDM5_ARB_RR_EN
    exp_q.push_back(cpu1); exp_q.push_back(dl0); exp_q.push_back(cpu2);
    exp_q.push_back(dl1);  exp_q.push_back(dl2);
`else
    exp_q.push_back(cpu1); exp_q.push_back(dl0); exp_q.push_back(dl1);
    exp_q.push_back(dl2);  exp_q.push_back(cpu2);
`endif
    rd_data = 8'hC3;
    ack_hold = 1'b1;
    cpu_we = 1'b1; cpu_addr = 25'h200; cpu_din = 8'h22; cpu_req = 1'b1;
    tick(); tick();
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h80 + 25'(i); ioctl_dout = 8'hE0 + 8'(i);
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    ack_hold = 1'b0;
    wait_cpu_ack(40, ok);
    checks++; if (!ok) $display("FAIL prio_cpu1_ack: got none required pulse"); else passed++;
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_we = 1'b0; cpu_addr = 25'h300; cpu_din = 8'h00; cpu_req = 1'b1;
    wait_cpu_ack(100, ok);
    checks++; if (!ok) $display("FAIL prio_cpu2_ack: got none required pulse"); else passed++;
    checks++; if (cpu_dout !== 8'hC3) $display("FAIL prio_cpu2_dout: got %h required c3", cpu_dout); else passed++;
    tick();
    cpu_req = 1'b0;
    wait_log(5, ok);
    checks++; if (!ok) $display("FAIL prio_timeout: got %0d accesses required 5", obs_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (obs_q.size() > 0) begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        checks++; if (got !== want) $display("FAIL prio_order[%0d]: got %h required %h", i, got, want); else passed++;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    obs_q.delete(); exp_q.delete();
    ack_hold = 1'b1;
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'h60 + 8'(i);
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    @(negedge clk_sys);
    checks++; if (mem_req !== 1'b1 || dl_busy !== 1'b1) $display("FAIL rstmid_pre: got req=%b busy=%b required 1/1", mem_req, dl_busy); else passed++;
    tick();
    reset = 1'b1; ioctl_download = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_req_drop: got %b required 0", mem_req); else passed++;
    checks++; if (dl_busy !== 1'b0) $display("FAIL rstmid_busy: got %b required 0", dl_busy); else passed++;
    tick(); tick();
    reset = 1'b0; ack_hold = 1'b0;
    repeat (10) tick();
    checks++; if (obs_q.size() != 0 || mem_req !== 1'b0) $display("FAIL rstmid_fifo_empty: got %0d accesses req=%b required 0/0", obs_q.size(), mem_req); else passed++;
    checks++; if (dl_busy !== 1'b0) $display("FAIL rstmid_busy_after: got %b required 0", dl_busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_rom_download();
    test_cas_download();
    test_cpu_read();
    test_overflow();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
